// File: rtl/led_pkg.sv
// Shared types and default widths for the LED pattern sequencer.
// The ROM (mem) uses the same address and divisor widths.
package led_pkg;

  localparam int MEM_ADDR = 3;
  localparam int DIV_W    = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Control and status bundle between a host and led_seq_ctrl.
// The host side is master; the sequencer side is slave.
interface led_seq_ctrl_if #(
  parameter int MEM_ADDR = led_pkg::MEM_ADDR,
  parameter int DIV_W    = led_pkg::DIV_W
);

  logic                start;
  logic                stop;
  logic                pause;
  logic                one_shot;
  logic                dir;
  logic [DIV_W-1:0]    div;
  logic                step_req;
  logic [MEM_ADDR-1:0] addr;
  logic                step;
  logic                led_strobe;
  logic                done;
  logic                busy;

  modport master (
    output start, stop, pause, one_shot,
    output dir, div, step_req,
    input  addr, step, led_strobe, done, busy
  );

  modport slave (
    input  start, stop, pause, one_shot,
    input  dir, div, step_req,
    output addr, step, led_strobe, done, busy
  );

endinterface

// File: rtl/led_prescaler.sv
// Step-rate divider: counts 0..divisor and fires tick on the last count.
// hold freezes the count; clear returns it to zero and masks tick.
module led_prescaler #(
  parameter int DIV_W = led_pkg::DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             hold,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = !clear && !hold &&
                (cnt == divisor);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// Walks the LED ROM address as a chase: free-run, one-shot or manual step.
// led_strobe trails step by one cycle to cover the ROM read latency.
module led_seq_ctrl #(
  parameter int MEM_ADDR = led_pkg::MEM_ADDR,
  parameter int DIV_W    = led_pkg::DIV_W
) (
  input  logic           clk,
  input  logic           rst,
  led_seq_ctrl_if.slave  bus
);

  import led_pkg::*;

  state_t              state;
  state_t              state_nxt;
  logic [DIV_W-1:0]    div_l;
  logic                dir_l;
  logic                os_l;
  logic [MEM_ADDR-1:0] origin;
  logic [MEM_ADDR-1:0] addr_q;
  logic [MEM_ADDR-1:0] addr_nxt;
  logic                step_q;
  logic                strobe_q;
  logic                done_q;
  logic                run;
  logic                clear;
  logic                tick;
  logic                go;
  logic                man;
  logic                adv;
  logic                adv_dir;
  logic                fin;

  assign run   = (state == RUN);
  assign clear = !run || bus.stop;

  led_prescaler #(
    .DIV_W (DIV_W)
  ) u_pre (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .hold    (bus.pause),
    .divisor (div_l),
    .tick    (tick)
  );

  // Terms are mutually exclusive so the decoder below stays unique.
  assign go  = !bus.stop && !run && bus.start;
  assign man = !bus.stop && !run && !bus.start &&
               bus.step_req;
  assign adv = tick || man;

  assign adv_dir  = run ? dir_l : bus.dir;
  assign addr_nxt = adv_dir ? addr_q - MEM_ADDR'(1)
                            : addr_q + MEM_ADDR'(1);
  assign fin      = tick && os_l &&
                    (addr_nxt == origin);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      bus.stop: state_nxt = IDLE;
      go:       state_nxt = RUN;
      fin:      state_nxt = DONE;
      default:  state_nxt = state;
    endcase
  end

  always_comb begin
    bus.busy = run;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_l    <= '0;
      dir_l    <= 1'b0;
      os_l     <= 1'b0;
      origin   <= '0;
      addr_q   <= '0;
      step_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (go) begin
        div_l  <= bus.div;
        dir_l  <= bus.dir;
        os_l   <= bus.one_shot;
        origin <= addr_q;
      end
      if (adv) begin
        addr_q <= addr_nxt;
      end
      step_q   <= adv;
      strobe_q <= step_q;
      done_q   <= fin;
    end
  end

  assign bus.addr       = addr_q;
  assign bus.step       = step_q;
  assign bus.led_strobe = strobe_q;
  assign bus.done       = done_q;

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Sequencer that drives the address port of the LED pattern ROM (`mem`) so the stored pattern plays out as a visible chase. A programmable prescaler divides `clk` down to a step rate. On each step a state machine walks the ROM address up or down, with wrap. The block supports free-running, one-shot and manual single-step operation, and emits a strobe aligned to the ROM's one-cycle read latency so downstream logic knows when `led_out` is fresh.

## Interface
- `MEM_ADDR`, 3: ROM address width; sequence length is 2**MEM_ADDR.
- `DIV_W`, 24: prescaler divisor width.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  pulse: begin playback (IDLE/DONE -> RUN).
- `stop`  in  1  pulse: abort playback (any state -> IDLE).
- `pause`  in  1  level: while high in RUN, steps are suppressed.
- `one_shot`  in  1  sampled at start: 1 = stop after one full pass, 0 = loop forever.
- `dir`  in  1  sampled at start: 0 = increment address, 1 = decrement.
- `div`  in  DIV_W  sampled at start: step period = div+1 clk cycles.
- `step_req`  in  1  pulse: in IDLE or DONE, advance one address immediately.
- `addr`  out  MEM_ADDR  ROM address, registered.
- `step`  out  1  one-cycle pulse, coincident with each `addr` change.
- `led_strobe`  out  1  `step` delayed one cycle; `led_out` valid for new address.
- `done`  out  1  one-cycle pulse when a one-shot pass completes.
- `busy`  out  1  high in RUN.

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN on `start`. At that edge:
  - latch `div`, `dir` and `one_shot`;
  - clear the prescaler;
  - record the current `addr` as `origin`.
- RUN:
  - The prescaler counts 0..div_l.
  - When it reaches div_l with `pause` low, a tick is issued: `addr` <= `addr` ± 1 modulo 2**MEM_ADDR, `step`=1, and the prescaler returns to 0.
  - With `pause` high, the prescaler holds its value and no tick occurs.
- One-shot: when a tick would move `addr` back to `origin`, the move still happens. `addr` therefore ends at `origin` after exactly 2**MEM_ADDR ticks. In the same cycle `done`=1 and the state goes to DONE.
- Loop mode: wrap 7->0 (up) or 0->7 (down) is seamless, with no extra cycle.
- DONE behaves as IDLE: `start` re-arms and `step_req` is honoured.
- `step_req` in IDLE/DONE: `addr` ± 1 using the live `dir` input. `step`=1 in the same cycle. `step_req` is ignored in RUN.
- `stop` forces IDLE from any state. `addr` holds its value and the prescaler clears.
- Priority in one cycle: `stop` > `start` > tick/`step_req`.
  - `start` and `stop` together: stays or goes IDLE.
  - `start` together with `step_req` in IDLE: start wins; no step.
- `div`=0 gives a tick every clk cycle in RUN.
- `div`, `dir` and `one_shot` changes during RUN have no effect until the next `start`.

## Timing
- Reset values: state=IDLE, `addr`=0, `step`=0, `led_strobe`=0, `done`=0, `busy`=0, prescaler=0.
- First tick after `start` occurs div+1 cycles after the start edge. Successive ticks are div+1 cycles apart, excluding paused cycles.
- `addr`, `step` and `done` are all registered and change on the same edge.
- `led_strobe` is asserted one cycle after `step`, matching the ROM's registered read.
- `busy` rises the cycle after `start` is sampled. It falls the cycle after `done` or `stop`.
- If `rst` is asserted mid-pass, all outputs go to their reset values immediately, regardless of clock.

## Structure
- Shared package `led_pkg`:
  - state enum (IDLE, RUN, DONE);
  - `MEM_ADDR` and `DIV_W` defaults, shared with `mem`.
- One sub-module, `led_prescaler`:
  - inputs: clear, hold, divisor;
  - output: tick.
- FSM, address counter and strobe alignment stay in the top level.

## Test plan
- Reset check: `rst` high then low → `addr`=0, all pulses 0, `busy`=0.
- Loop mode up: `div`=3, `dir`=0, `one_shot`=0, `start` → `addr` steps every 4 cycles, 0,1,…,7,0,1. `led_strobe` trails each `step` by 1 cycle.
- One-shot down: from `addr`=2, `div`=0, `dir`=1, `start` →
  - `addr` sequence 1,0,7,…,3,2 on consecutive cycles;
  - `done` pulses once with `addr`=2;
  - state is DONE and `busy`=0.
- Pause and stop: `div`=4, start, `pause` high for 10 cycles mid-count →
  - tick is delayed exactly 10 cycles;
  - then `stop` → `addr` frozen, `busy`=0, no further `step`.
- Single step: in IDLE with `addr`=7 and `dir`=0, pulse `step_req` → `addr`=0, `step`=1 in the same cycle. `step_req` during RUN is ignored.
- Collisions and reset mid-run:
  - `start`+`stop` together → stays IDLE;
  - async `rst` mid-RUN → outputs reset without waiting for a clock edge.
